// File: rtl/router_top.sv
`default_nettype none
// router_top -- 1x3 byte-serial packet router, three DEPTH-entry output FIFOs (rev 1.0).
// Optional `define SOFT_RESET_EN: flush a port whose data sits unread for TIMEOUT cycles.
module router_top #(
  parameter int DEPTH = 16
`ifdef SOFT_RESET_EN
  , parameter int TIMEOUT = 30
`endif
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       err,
  output logic       busy,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic [7:0] data_out_2
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] DA  = 3'd0;
  localparam logic [2:0] WTE = 3'd1;
  localparam logic [2:0] LFD = 3'd2;
  localparam logic [2:0] LD  = 3'd3;
  localparam logic [2:0] FFS = 3'd4;
  localparam logic [2:0] LAF = 3'd5;
  localparam logic [2:0] LP  = 3'd6;
  localparam logic [2:0] CPE = 3'd7;

  logic [2:0] state, state_nx;
  logic [1:0] addr_q;
  logic [7:0] hdr_q, hold_q, par_q, calc_q;
  logic       hold_par_q, hold_pend_q;
  logic [2:0] read_enb, full_v, empty_v, wr_en, flush;
  logic       hdr_empty, tgt_full, tgt_empty, tgt_flush;
  logic       we;
  logic [7:0] wdata;

  assign read_enb = {read_enb_2, read_enb_1, read_enb_0};

  always_comb begin
    hdr_empty = 1'b0;
    case (data_in[1:0])
      2'd0:    hdr_empty = empty_v[0];
      2'd1:    hdr_empty = empty_v[1];
      2'd2:    hdr_empty = empty_v[2];
      default: hdr_empty = 1'b0;
    endcase
    tgt_full  = 1'b0;
    tgt_empty = 1'b0;
    tgt_flush = 1'b0;
    case (addr_q)
      2'd0:    begin tgt_full = full_v[0]; tgt_empty = empty_v[0]; tgt_flush = flush[0]; end
      2'd1:    begin tgt_full = full_v[1]; tgt_empty = empty_v[1]; tgt_flush = flush[1]; end
      2'd2:    begin tgt_full = full_v[2]; tgt_empty = empty_v[2]; tgt_flush = flush[2]; end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= DA;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      DA:  if (pkt_valid && data_in[1:0] != 2'd3) state_nx = hdr_empty ? LFD : WTE;
      WTE: if (tgt_empty) state_nx = LFD;
      LFD: state_nx = LD;
      LD:  if (tgt_full) state_nx = FFS;
           else if (!pkt_valid) state_nx = LP;
      FFS: if (!tgt_full) state_nx = LAF;
      // Reached from CPE with nothing held: the wait only stalls the next header.
      LAF: if (!hold_pend_q) state_nx = DA;
           else if (hold_par_q) state_nx = CPE;
           else state_nx = LD;
      LP:  state_nx = CPE;
      CPE: state_nx = tgt_full ? FFS : DA;
      default: state_nx = DA;
    endcase
    if (tgt_flush && state != DA) state_nx = DA;
  end

  always_comb begin
    busy  = !(state == DA || state == LD);
    we    = 1'b0;
    wdata = 8'h00;
    case (state)
      LFD: begin we = 1'b1; wdata = hdr_q; end
      LD:  if (!tgt_full && pkt_valid) begin we = 1'b1; wdata = data_in; end
      LAF: if (hold_pend_q) begin we = 1'b1; wdata = hold_q; end
      LP:  begin we = 1'b1; wdata = par_q; end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q      <= 2'd0;
      hdr_q       <= 8'h00;
      hold_q      <= 8'h00;
      par_q       <= 8'h00;
      calc_q      <= 8'h00;
      hold_par_q  <= 1'b0;
      hold_pend_q <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        DA: if (pkt_valid && data_in[1:0] != 2'd3) begin
          addr_q <= data_in[1:0];
          hdr_q  <= data_in;
        end
        LFD: begin
          err         <= 1'b0;
          calc_q      <= hdr_q;
          hold_pend_q <= 1'b0;
        end
        LD: begin
          if (tgt_full) begin
            hold_q      <= data_in;
            hold_par_q  <= !pkt_valid;
            hold_pend_q <= 1'b1;
          end else if (pkt_valid) begin
            calc_q <= calc_q ^ data_in;
          end
          if (!pkt_valid) par_q <= data_in;
        end
        LAF: if (hold_pend_q) begin
          hold_pend_q <= 1'b0;
          if (!hold_par_q) calc_q <= calc_q ^ hold_q;
        end
        CPE: if (calc_q != par_q) err <= 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_fifo
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic [7:0]    dout;
    logic          do_wr, do_rd;

    assign wr_en[i]   = we && (addr_q == 2'(i));
    assign empty_v[i] = (cnt == '0);
    assign full_v[i]  = (cnt == CW'(DEPTH));
    assign do_wr      = wr_en[i] && !full_v[i] && !flush[i];
    assign do_rd      = read_enb[i] && !empty_v[i] && !flush[i];

    always_ff @(posedge clock) begin
      if (do_wr) mem[wp] <= wdata;
    end

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        wp   <= '0;
        rp   <= '0;
        cnt  <= '0;
        dout <= 8'h00;
      end else if (flush[i]) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (do_wr) wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + 1'b1;
        if (do_rd) begin
          dout <= mem[rp];
          rp   <= (rp == AW'(DEPTH - 1)) ? '0 : rp + 1'b1;
        end
        if (do_wr && !do_rd)      cnt <= cnt + 1'b1;
        else if (!do_wr && do_rd) cnt <= cnt - 1'b1;
      end
    end
  end

`ifdef SOFT_RESET_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  for (genvar i = 0; i < 3; i++) begin : g_soft
    logic [TW-1:0] tcnt;
    logic          stall;
    assign stall    = !empty_v[i] && !read_enb[i];
    assign flush[i] = stall && (tcnt == TW'(TIMEOUT - 1));
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)                tcnt <= '0;
      else if (stall && !flush[i]) tcnt <= tcnt + 1'b1;
      else                        tcnt <= '0;
    end
  end
`else
  assign flush = 3'b000;
`endif

  assign vld_out_0  = !empty_v[0];
  assign vld_out_1  = !empty_v[1];
  assign vld_out_2  = !empty_v[2];
  assign data_out_0 = g_fifo[0].dout;
  assign data_out_1 = g_fifo[1].dout;
  assign data_out_2 = g_fifo[2].dout;
endmodule
`default_nettype wire

// File: tb/tb_router_top.sv
`default_nettype none
// tb_router_top -- table-driven packet vectors plus directed multi-cycle sequences for router_top.
module tb_router_top;
  logic       clock = 1'b0;
  logic       resetn, read_enb_0, read_enb_1, read_enb_2, pkt_valid;
  logic [7:0] data_in;
  logic       vld_out_0, vld_out_1, vld_out_2, err, busy;
  logic [7:0] data_out_0, data_out_1, data_out_2;

  always #5 clock = ~clock;

  router_top dut (
    .clock(clock), .resetn(resetn),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .pkt_valid(pkt_valid), .data_in(data_in),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .err(err), .busy(busy),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] q0[$], q1[$], q2[$];
  logic pend0 = 1'b0, pend1 = 1'b0, pend2 = 1'b0;

  // Capture each byte read out, one half-cycle after the edge that read it.
  always @(negedge clock) begin
    if (pend0) q0.push_back(data_out_0);
    if (pend1) q1.push_back(data_out_1);
    if (pend2) q2.push_back(data_out_2);
    pend0 = resetn && read_enb_0 && vld_out_0;
    pend1 = resetn && read_enb_1 && vld_out_1;
    pend2 = resetn && read_enb_2 && vld_out_2;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int p);
    case (p)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [7:0] qget(input int p, input int i);
    if (i >= qsize(p)) return 8'hxx;
    case (p)
      0:       return q0[i];
      1:       return q1[i];
      default: return q2[i];
    endcase
  endfunction

  task automatic qclear();
    q0.delete(); q1.delete(); q2.delete();
  endtask

  task automatic set_rd(input int p, input logic v);
    case (p)
      0:       read_enb_0 = v;
      1:       read_enb_1 = v;
      default: read_enb_2 = v;
    endcase
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // A byte is taken at every edge where busy was low during the preceding cycle.
  task automatic send_pkt(input logic [7:0] hdr, input int len, input logic [7:0] base,
                          input logic [7:0] par, output logic ok);
    logic [7:0] b[$];
    logic bz;
    int k, budget;
    b.push_back(hdr);
    for (int j = 0; j < len; j++) b.push_back(base + 8'(j));
    b.push_back(par);
    k = 0; budget = 0; ok = 1'b1;
    while (k < b.size()) begin
      data_in   = b[k];
      pkt_valid = (k < b.size() - 1);
      @(negedge clock);
      bz = busy;
      tick();
      if (!bz) k++;
      budget++;
      if (budget > 200) begin ok = 1'b0; break; end
    end
    pkt_valid = 1'b0;
    data_in   = 8'h00;
  endtask

  task automatic drain(input int p, input int n);
    int t;
    t = 0;
    set_rd(p, 1'b1);
    while (qsize(p) < n && t < 100) begin tick(); t++; end
    set_rd(p, 1'b0);
    repeat (3) tick();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 50) begin tick(); t++; end
  endtask

  task automatic chk_stream(input string name, input int p, input logic [7:0] exp[$]);
    chk({name, "_count"}, qsize(p), exp.size());
    for (int j = 0; j < exp.size(); j++) chk($sformatf("%s_byte%0d", name, j), qget(p, j), exp[j]);
  endtask

  typedef struct {
    logic [1:0] addr;
    int         len;
    logic [7:0] base;
    logic [7:0] par;
    logic       exp_err;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic ok;
    logic [7:0] hdr;
    logic [7:0] exp[$];

    vt[0] = '{2'd0, 14, 8'h00, 8'h39, 1'b0};
    vt[1] = '{2'd1, 4,  8'h00, 8'h00, 1'b1};
    vt[2] = '{2'd1, 4,  8'h00, 8'h11, 1'b0};
    vt[3] = '{2'd2, 1,  8'hA5, 8'hA3, 1'b0};
    vt[4] = '{2'd2, 0,  8'h00, 8'h02, 1'b0};
    vt[5] = '{2'd0, 3,  8'hF0, 8'hFF, 1'b0};
    vt[6] = '{2'd2, 2,  8'h10, 8'h55, 1'b1};

    resetn = 1'b0; pkt_valid = 1'b0; data_in = 8'h00;
    read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    @(negedge clock);
    chk("rst_vld", {29'd0, vld_out_2, vld_out_1, vld_out_0}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_dout", {8'h00, data_out_2, data_out_1, data_out_0}, 0);
    tick();

    for (int v = 0; v < 7; v++) begin
      hdr = {6'(vt[v].len), vt[v].addr};
      qclear();
      send_pkt(hdr, vt[v].len, vt[v].base, vt[v].par, ok);
      chk($sformatf("v%0d_sent", v), ok, 1);
      repeat (2) tick();
      chk($sformatf("v%0d_err", v), err, vt[v].exp_err);
      drain(vt[v].addr, vt[v].len + 2);
      exp.delete();
      exp.push_back(hdr);
      for (int j = 0; j < vt[v].len; j++) exp.push_back(vt[v].base + 8'(j));
      exp.push_back(vt[v].par);
      chk_stream($sformatf("v%0d", v), vt[v].addr, exp);
      chk($sformatf("v%0d_vld_end", v), {29'd0, vld_out_2, vld_out_1, vld_out_0}, 0);
      wait_idle();
      chk($sformatf("v%0d_idle", v), busy, 0);
    end

    // Overflow into FFS: 19 bytes into a 16-entry FIFO with no reader.
    qclear();
    fork
      send_pkt(8'h44, 17, 8'h00, 8'h54, ok);
      begin
        repeat (22) tick();
        @(negedge clock);
        chk("ffs_busy", busy, 1);
        chk("ffs_vld", vld_out_0, 1);
        tick();
        read_enb_0 = 1'b1;
      end
    join
    chk("ffs_sent", ok, 1);
    drain(0, 19);
    exp.delete();
    exp.push_back(8'h44);
    for (int j = 0; j < 17; j++) exp.push_back(8'(j));
    exp.push_back(8'h54);
    chk_stream("ffs", 0, exp);
    chk("ffs_err", err, 0);
    chk("ffs_vld_end", vld_out_0, 0);
    wait_idle();

    // Invalid address 3 is ignored.
    data_in = 8'h07; pkt_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk($sformatf("addr3_busy%0d", c), busy, 0);
      chk($sformatf("addr3_vld%0d", c), {29'd0, vld_out_2, vld_out_1, vld_out_0}, 0);
      tick();
    end
    pkt_valid = 1'b0; data_in = 8'h00;
    tick();

    // Second packet to a non-empty port waits in WTE.
    qclear();
    send_pkt(8'h06, 1, 8'hA5, 8'hA3, ok);
    chk("wte_first_sent", ok, 1);
    fork
      send_pkt(8'h0A, 2, 8'h10, 8'h0B, ok);
      begin
        repeat (8) tick();
        @(negedge clock);
        chk("wte_busy", busy, 1);
        chk("wte_vld", vld_out_2, 1);
        tick();
        read_enb_2 = 1'b1;
      end
    join
    chk("wte_second_sent", ok, 1);
    drain(2, 7);
    exp.delete();
    exp.push_back(8'h06); exp.push_back(8'hA5); exp.push_back(8'hA3);
    exp.push_back(8'h0A); exp.push_back(8'h10); exp.push_back(8'h11); exp.push_back(8'h0B);
    chk_stream("wte", 2, exp);
    wait_idle();

    // Asynchronous reset in the middle of a packet.
    send_pkt(8'h00, 0, 8'h00, 8'hFF, ok);
    repeat (2) tick();
    chk("mid_pre_err", err, 1);
    data_in = 8'h29; pkt_valid = 1'b1;
    tick(); tick();
    data_in = 8'h00; tick();
    data_in = 8'h01; tick();
    chk("mid_pre_vld1", vld_out_1, 1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_vld", {29'd0, vld_out_2, vld_out_1, vld_out_0}, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dout", {8'h00, data_out_2, data_out_1, data_out_0}, 0);
    pkt_valid = 1'b0; data_in = 8'h00;
    tick();
    resetn = 1'b1;
    tick();
    qclear();
    send_pkt(8'h11, 4, 8'h00, 8'h11, ok);
    chk("post_rst_sent", ok, 1);
    repeat (2) tick();
    drain(1, 6);
    exp.delete();
    exp.push_back(8'h11);
    for (int j = 0; j < 4; j++) exp.push_back(8'(j));
    exp.push_back(8'h11);
    chk_stream("post_rst", 1, exp);
    chk("post_rst_err", err, 0);

`ifdef SOFT_RESET_EN
    wait_idle();
    send_pkt(8'h06, 1, 8'hA5, 8'hA3, ok);
    chk("soft_sent", ok, 1);
    repeat (24) tick();
    @(negedge clock);
    chk("soft_vld_before", vld_out_2, 1);
    tick();
    repeat (6) tick();
    @(negedge clock);
    chk("soft_vld_after", vld_out_2, 0);
    chk("soft_busy_after", busy, 0);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
